instruction_memory_loader: RTL and testbench

Byte-stream program loader: the write side of the instruction memory. Accepts a framed byte stream over a valid/ready handshake, decodes start address and length, and issues one byte-wide write per payload byte into the instruction memory's little-endian byte array. Holds the CPU while a frame is in flight and reports completion or framing errors.

---
 rtl/instruction_memory_loader.sv | 162 ++++++++++++++++
 tb/tb_instruction_memory_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loader.sv
// Framed byte-stream loader driving byte writes into instruction memory.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module instruction_memory_loader #(
  parameter int I_ADDR_W       = 12,
  parameter int I_MEMORY_DEPTH = 1 << I_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                mem_we,
  output logic [I_ADDR_W-1:0] mem_waddr,
  output logic [7:0]          mem_wdata,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, CSUM
  } state_t;

  localparam logic [7:0]  SYNC  = 8'hA5;
  localparam logic [16:0] DEPTH = 17'(I_MEMORY_DEPTH);

  state_t state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [15:0] len_full;
  logic        acc;
  logic        we_d, hold_d, done_d, err_d;
  logic [I_ADDR_W-1:0] waddr_d;
  logic [7:0]          wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d, sum_chk;
`endif

  assign acc      = rx_valid && rx_ready;
  assign len_full = {rx_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    we_d    = 1'b0;
    waddr_d = mem_waddr;
    wdata_d = mem_wdata;
    hold_d  = cpu_hold;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    sum_chk = sum_q + rx_data;
`endif
    if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == SYNC) begin
            state_d = ADDR_LO;
            hold_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = 8'h00;
`endif
          end
        end
        ADDR_LO: begin
          addr_d  = {8'h00, rx_data};
          state_d = ADDR_HI;
        end
        ADDR_HI: begin
          addr_d  = {rx_data, addr_q[7:0]};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d   = {8'h00, rx_data};
          state_d = LEN_HI;
        end
        LEN_HI: begin
          len_d = len_full;
          if ({1'b0, len_full} > DEPTH) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = IDLE;
`endif
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          // upper address bits beyond I_ADDR_W fall away, giving the wrap
          we_d    = 1'b1;
          waddr_d = addr_q[I_ADDR_W-1:0];
          wdata_d = rx_data;
          addr_d  = addr_q + 16'd1;
          len_d   = len_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_chk;
          if (len_q == 16'd1) state_d = CSUM;
`else
          if (len_q == 16'd1) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = IDLE;
          end
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          state_d = IDLE;
          if (sum_chk == 8'h00) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      rx_ready  <= 1'b1;
      mem_we    <= we_d;
      mem_waddr <= waddr_d;
      mem_wdata <= wdata_d;
      cpu_hold  <= hold_d;
      done      <= done_d;
      error     <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Bench for instruction_memory_loader: frame table, corner sequences,
// and random frames against a byte-position frame model.
module tb_instruction_memory_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready, mem_we, cpu_hold, done, error;
  logic [11:0] mem_waddr;
  logic [7:0]  mem_wdata;

  always #5 clk = ~clk;

  instruction_memory_loader dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int n_we = 0, n_done = 0, n_err = 0;
  logic [7:0] dut_mem [4096];
  logic [7:0] ref_mem [4096];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // reference model: tracks position of each byte within the frame
  int         m_pos = -1;
  logic [7:0] m_hdr [4];
  int         m_len, m_base;
  int         m_sum;
  logic       e_ready = 0, e_we = 0, e_hold = 0, e_done = 0, e_err = 0;
  logic [11:0] e_waddr = 0;
  logic [7:0]  e_wdata = 0;

  task automatic finish_ok();
    e_done = 1'b1;
    e_hold = 1'b0;
    m_pos  = -1;
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    bit acc;
    int k;
    if (r) begin
      e_ready = 0; e_we = 0; e_waddr = 0; e_wdata = 0;
      e_hold = 0; e_done = 0; e_err = 0; m_pos = -1;
      return;
    end
    acc = v && e_ready;
    e_ready = 1; e_we = 0; e_done = 0; e_err = 0;
    if (!acc) return;
    if (m_pos < 0) begin
      if (d == 8'hA5) begin
        m_pos = 0; e_hold = 1; m_sum = 0;
      end
      return;
    end
    m_pos++;
    if (m_pos <= 4) begin
      m_hdr[m_pos-1] = d;
      if (m_pos == 4) begin
        m_base = int'({m_hdr[1], m_hdr[0]}) % 4096;
        m_len  = int'({m_hdr[3], m_hdr[2]});
        if (m_len > 4096) begin
          e_err = 1; m_pos = -1;
        end else if (m_len == 0 && !CS) begin
          finish_ok();
        end
      end
      return;
    end
    k = m_pos - 5;
    if (k < m_len) begin
      e_we = 1;
      e_waddr = 12'((m_base + k) % 4096);
      e_wdata = d;
      ref_mem[e_waddr] = d;
      m_sum = m_sum + int'(d);
      if (k == m_len - 1 && !CS) finish_ok();
    end else if (((m_sum + int'(d)) % 256) == 0) begin
      finish_ok();
    end else begin
      e_err = 1; m_pos = -1;
    end
  endtask

  always @(posedge clk) begin
    model_step(rst, rx_valid, rx_data);
    #1;
    chk("cycle", int'({rx_ready, mem_we, mem_waddr, mem_wdata,
                       cpu_hold, done, error}),
                 int'({e_ready, e_we, e_waddr, e_wdata,
                       e_hold, e_done, e_err}));
    if (mem_we) begin
      dut_mem[mem_waddr] = mem_wdata;
      n_we++;
    end
    if (done) n_done++;
    if (error) n_err++;
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  typedef logic [7:0] bytes_t [12];
  typedef struct {
    string      nm;
    bytes_t     b;
    int         n;
    logic [7:0] cs;
    bit         hascs;
    int         gap;
    int         wr, dn, er;
    logic       hold;
  } vec_t;
  vec_t tbl[$];

  task automatic rand_frame();
    logic [7:0]  b, s;
    logic [15:0] a, l;
    int g, len, gp;
    bit big;
    g = $urandom_range(0, 2);
    repeat (g) begin
      do b = 8'($urandom); while (b == 8'hA5);
      send(b, $urandom_range(0, 1));
    end
    a   = 16'($urandom);
    big = ($urandom_range(0, 7) == 0);
    len = big ? 4097 + $urandom_range(0, 60000) : $urandom_range(0, 24);
    l   = 16'(len);
    gp  = ($urandom_range(0, 2) == 0) ? 1 : 0;
    send(8'hA5, gp);
    send(a[7:0], gp);
    send(a[15:8], gp);
    send(l[7:0], gp);
    send(l[15:8], gp);
    if (!big) begin
      s = 8'h00;
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        s = s + b;
        send(b, ($urandom_range(0, 3) == 0) ? 1 : 0);
      end
      if (CS) begin
        b = 8'h00 - s;
        if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
        send(b, gp);
      end
    end
    idle($urandom_range(0, 2));
  endtask

  initial begin
    int w0, d0, e0, mism;
    logic [7:0] s;
    for (int i = 0; i < 4096; i++) begin
      dut_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end

    tbl.push_back('{"basic",
      '{8'hA5, 8'h10, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03,
        8'h04, 8'h00, 8'h00, 8'h00}, 9, 8'hF6, 1'b1, 0, 4, 1, 0, 1'b0});
    tbl.push_back('{"wrap",
      '{8'hA5, 8'hFE, 8'h0F, 8'h04, 8'h00, 8'hAA, 8'hBB, 8'hCC,
        8'hDD, 8'h00, 8'h00, 8'h00}, 9, 8'hF2, 1'b1, 2, 4, 1, 0, 1'b0});
    tbl.push_back('{"oversize",
      '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00}, 5, 8'h00, 1'b0, 0, 0, 0, 1, 1'b1});
    tbl.push_back('{"recover_hi_trunc",
      '{8'hA5, 8'hF5, 8'hF5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00}, 7, 8'hCD, 1'b1, 1, 2, 1, 0, 1'b0});
    tbl.push_back('{"garbage_len0",
      '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h20, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00}, 8, 8'h00, 1'b1, 1, 0, 1, 0, 1'b0});
`ifdef LOADER_CHECKSUM_EN
    tbl.push_back('{"bad_csum",
      '{8'hA5, 8'h10, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03,
        8'h04, 8'h00, 8'h00, 8'h00}, 9, 8'h00, 1'b1, 0, 4, 0, 1, 1'b1});
    tbl.push_back('{"good_csum",
      '{8'hA5, 8'h10, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03,
        8'h04, 8'h00, 8'h00, 8'h00}, 9, 8'hF6, 1'b1, 0, 4, 1, 0, 1'b0});
`endif

    idle(3);
    chk("reset_ready", int'(rx_ready), 0);
    chk("reset_hold", int'(cpu_hold), 0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < tbl.size(); i++) begin
      w0 = n_we; d0 = n_done; e0 = n_err;
      for (int j = 0; j < tbl[i].n; j++) send(tbl[i].b[j], tbl[i].gap);
      if (CS && tbl[i].hascs) send(tbl[i].cs, tbl[i].gap);
      idle(3);
      chk({tbl[i].nm, "_writes"}, n_we - w0, tbl[i].wr);
      chk({tbl[i].nm, "_done"}, n_done - d0, tbl[i].dn);
      chk({tbl[i].nm, "_error"}, n_err - e0, tbl[i].er);
      chk({tbl[i].nm, "_hold"}, int'(cpu_hold), int'(tbl[i].hold));
    end

    chk("mem_010", int'(dut_mem[12'h010]), 8'h01);
    chk("mem_013", int'(dut_mem[12'h013]), 8'h04);
    chk("mem_ffe", int'(dut_mem[12'hFFE]), 8'hAA);
    chk("mem_fff", int'(dut_mem[12'hFFF]), 8'hBB);
    chk("mem_000", int'(dut_mem[12'h000]), 8'hCC);
    chk("mem_001", int'(dut_mem[12'h001]), 8'hDD);
    chk("mem_5f5", int'(dut_mem[12'h5F5]), 8'h11);
    chk("mem_5f6", int'(dut_mem[12'h5F6]), 8'h22);

    // reset after two of four payload bytes
    w0 = n_we;
    send(8'hA5, 0); send(8'h40, 0); send(8'h00, 0);
    send(8'h04, 0); send(8'h00, 0); send(8'h01, 0); send(8'h02, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_hold", int'(cpu_hold), 0);
    chk("midrst_ready", int'(rx_ready), 0);
    rst = 1'b0;
    idle(3);
    chk("midrst_writes", n_we - w0, 2);
    chk("midrst_mem_040", int'(dut_mem[12'h040]), 8'h01);
    chk("midrst_mem_042", int'(dut_mem[12'h042]), 8'h00);
    d0 = n_done;
    send(8'hA5, 0); send(8'h40, 0); send(8'h00, 0);
    send(8'h04, 0); send(8'h00, 0);
    send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 0);
    if (CS) send(8'hE6, 0);
    idle(3);
    chk("after_rst_done", n_done - d0, 1);
    chk("after_rst_mem_043", int'(dut_mem[12'h043]), 8'h08);

    // LEN exactly equal to memory depth is accepted
    w0 = n_we; d0 = n_done;
    send(8'hA5, 0); send(8'h00, 0); send(8'h03, 0);
    send(8'h00, 0); send(8'h10, 0);
    s = 8'h00;
    for (int i = 0; i < 4096; i++) begin
      send(8'(i * 7 + 1), 0);
      s = s + 8'(i * 7 + 1);
    end
    if (CS) send(8'h00 - s, 0);
    idle(3);
    chk("full_writes", n_we - w0, 4096);
    chk("full_done", n_done - d0, 1);
    chk("full_first", int'(dut_mem[12'h300]), 8'h01);
    chk("full_last", int'(dut_mem[12'h2FF]), 8'hFA);

    for (int f = 0; f < 40; f++) rand_frame();
    idle(4);

    mism = 0;
    for (int i = 0; i < 4096; i++)
      if (dut_mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
